// File: rtl/bs_shift_acc_array.sv
// Multi-lane bit-serial shift-accumulate, MSB plane first; result registered 1 cycle after last plane.
// One plane/cycle while accumulating; result held with out_vld until out_rdy, planes stalled meanwhile.
module bs_shift_acc_array #(
  parameter int LANES    = 4,
  parameter int IN_W     = 20,
  parameter int ACC_W    = 32,
  parameter int MAX_BITS = 16,
  localparam int BW      = $clog2(MAX_BITS + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [BW-1:0]          bits,
  input  logic                   signed_md,
  input  logic [LANES*ACC_W-1:0] bias_in,
  input  logic                   plane_vld,
  output logic                   plane_rdy,
  input  logic [LANES*IN_W-1:0]  plane_in,
  input  logic                   abort,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic [LANES*ACC_W-1:0] out_data,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t           state;
  logic [BW-1:0]    cnt;
  logic [BW-1:0]    cnt_init;
  logic             first;
  logic             sgn_r;
  logic             accept;
  logic [ACC_W-1:0] acc     [LANES];
  logic [ACC_W-1:0] bias_r  [LANES];
  logic [ACC_W-1:0] p_ext   [LANES];
  logic [ACC_W-1:0] p_sel   [LANES];
  logic [ACC_W-1:0] acc_nxt [LANES];

  // A new job is taken from IDLE, or from HOLD on the same cycle the result is handed off.
  always_comb begin
    accept = start && ((state == IDLE) || ((state == HOLD) && out_rdy));
    if (bits == '0)
      cnt_init = BW'(1);
    else if (bits > BW'(MAX_BITS))
      cnt_init = BW'(MAX_BITS);
    else
      cnt_init = bits;
  end

  // Signed mode gives the MSB plane negative weight; bias joins on the final plane.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      p_ext[l]   = ACC_W'($signed(plane_in[l*IN_W +: IN_W]));
      p_sel[l]   = (sgn_r && first) ? (~p_ext[l] + 1'b1) : p_ext[l];
      acc_nxt[l] = {acc[l][ACC_W-2:0], 1'b0} + p_sel[l]
                   + ((cnt == BW'(1)) ? bias_r[l] : '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      first     <= 1'b0;
      sgn_r     <= 1'b0;
      plane_rdy <= 1'b0;
      out_vld   <= 1'b0;
      busy      <= 1'b0;
      out_data  <= '0;
      for (int l = 0; l < LANES; l++) begin
        acc[l]    <= '0;
        bias_r[l] <= '0;
      end
    end else if (abort) begin
      state     <= IDLE;
      plane_rdy <= 1'b0;
      out_vld   <= 1'b0;
      busy      <= 1'b0;
      for (int l = 0; l < LANES; l++)
        acc[l] <= '0;
    end else if (accept) begin
      state     <= ACCUM;
      cnt       <= cnt_init;
      first     <= 1'b1;
      sgn_r     <= signed_md;
      plane_rdy <= 1'b1;
      out_vld   <= 1'b0;
      busy      <= 1'b1;
      for (int l = 0; l < LANES; l++) begin
        acc[l]    <= '0;
        bias_r[l] <= bias_in[l*ACC_W +: ACC_W];
      end
    end else begin
      case (state)
        ACCUM: begin
          if (plane_vld) begin
            cnt   <= cnt - BW'(1);
            first <= 1'b0;
            for (int l = 0; l < LANES; l++)
              acc[l] <= acc_nxt[l];
            if (cnt == BW'(1)) begin
              state     <= HOLD;
              plane_rdy <= 1'b0;
              out_vld   <= 1'b1;
              for (int l = 0; l < LANES; l++)
                out_data[l*ACC_W +: ACC_W] <= acc_nxt[l];
            end
          end
        end
        HOLD: begin
          if (out_rdy) begin
            state   <= IDLE;
            out_vld <= 1'b0;
            busy    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bs_shift_acc_array.sv
// Bench for bs_shift_acc_array: directed scenarios plus random jobs against a weighted-sum model.
module tb_bs_shift_acc_array;
  localparam int LANES = 4, IN_W = 20, ACC_W = 32, MAX_BITS = 16, BW = 5;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   start = 1'b0;
  logic [BW-1:0]          bits = '0;
  logic                   signed_md = 1'b0;
  logic [LANES*ACC_W-1:0] bias_in = '0;
  logic                   plane_vld = 1'b0;
  logic                   plane_rdy;
  logic [LANES*IN_W-1:0]  plane_in = '0;
  logic                   abort = 1'b0;
  logic                   out_vld;
  logic                   out_rdy = 1'b1;
  logic [LANES*ACC_W-1:0] out_data;
  logic                   busy;

  logic       w_start = 1'b0, w_signed = 1'b0, w_pvld = 1'b0, w_abort = 1'b0, w_ordy = 1'b1;
  logic [2:0] w_bits = '0;
  logic [7:0] w_bias = '0, w_pin = '0;
  logic       w_prdy, w_ovld, w_busy;
  logic [7:0] w_odata;

  int n_cmp = 0;
  int n_bad = 0;

  logic signed [IN_W-1:0] pl [MAX_BITS][LANES];
  logic [ACC_W-1:0]       bias_v [LANES];

  always #5 clk = ~clk;

  bs_shift_acc_array #(.LANES(LANES), .IN_W(IN_W), .ACC_W(ACC_W), .MAX_BITS(MAX_BITS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bits(bits), .signed_md(signed_md),
    .bias_in(bias_in), .plane_vld(plane_vld), .plane_rdy(plane_rdy), .plane_in(plane_in),
    .abort(abort), .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .busy(busy)
  );

  bs_shift_acc_array #(.LANES(1), .IN_W(8), .ACC_W(8), .MAX_BITS(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(w_start), .bits(w_bits), .signed_md(w_signed),
    .bias_in(w_bias), .plane_vld(w_pvld), .plane_rdy(w_prdy), .plane_in(w_pin),
    .abort(w_abort), .out_vld(w_ovld), .out_rdy(w_ordy), .out_data(w_odata), .busy(w_busy)
  );

  // Result = bias + sum of plane_k * 2^(n-1-k), the first plane negated in signed mode.
  function automatic logic [ACC_W-1:0] model(input int lane, input int n, input bit s);
    longint sum, p, w;
    sum = 0;
    for (int k = 0; k < n; k++) begin
      p = longint'(pl[k][lane]);
      w = longint'(1) << (n - 1 - k);
      if (s && k == 0) sum = sum - p * w;
      else             sum = sum + p * w;
    end
    sum = sum + longint'(bias_v[lane]);
    return sum[ACC_W-1:0];
  endfunction

  task automatic rand_job();
    for (int k = 0; k < MAX_BITS; k++)
      for (int l = 0; l < LANES; l++)
        pl[k][l] = IN_W'($urandom);
    for (int l = 0; l < LANES; l++)
      bias_v[l] = $urandom;
  endtask

  task automatic drive_job(input int b, input bit s);
    bits      = BW'(b);
    signed_md = s;
    for (int l = 0; l < LANES; l++)
      bias_in[l*ACC_W +: ACC_W] = bias_v[l];
  endtask

  // Job parameters are scrambled right after the accept edge; the DUT must not care.
  task automatic start_job(input int b, input bit s);
    @(negedge clk);
    start = 1'b1;
    drive_job(b, s);
    @(negedge clk);
    start     = 1'b0;
    bits      = BW'($urandom);
    signed_md = 1'($urandom);
    for (int l = 0; l < LANES; l++)
      bias_in[l*ACC_W +: ACC_W] = $urandom;
  endtask

  task automatic feed(input int k0, input int k1, input int gap_max);
    for (int k = k0; k < k1; k++) begin
      repeat ($urandom_range(gap_max)) begin
        plane_vld = 1'b0;
        for (int l = 0; l < LANES; l++)
          plane_in[l*IN_W +: IN_W] = IN_W'($urandom);
        @(negedge clk);
      end
      plane_vld = 1'b1;
      for (int l = 0; l < LANES; l++)
        plane_in[l*IN_W +: IN_W] = pl[k][l];
      @(negedge clk);
      plane_vld = 1'b0;
    end
  endtask

  task automatic test_reset();
    n_cmp++; if (out_vld !== 1'b0) begin n_bad++; $display("FAIL reset_out_vld: got %b expected 0", out_vld); end
    n_cmp++; if (plane_rdy !== 1'b0) begin n_bad++; $display("FAIL reset_plane_rdy: got %b expected 0", plane_rdy); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
  endtask

  task automatic set_scenario1();
    rand_job();
    pl[0][0] = 3; pl[1][0] = 1; pl[2][0] = 0; pl[3][0] = 2; bias_v[0] = 5;
    pl[0][1] = 1; pl[1][1] = 0; pl[2][1] = 0; pl[3][1] = 0; bias_v[1] = 0;
  endtask

  task automatic test_unsigned_basic();
    set_scenario1();
    start_job(4, 1'b0);
    feed(0, 3, 0);
    n_cmp++; if (out_vld !== 1'b0) begin n_bad++; $display("FAIL early_out_vld: got %b expected 0", out_vld); end
    feed(3, 4, 0);
    n_cmp++; if (out_vld !== 1'b1) begin n_bad++; $display("FAIL latency_out_vld: got %b expected 1", out_vld); end
    n_cmp++; if (out_data[31:0] !== 32'd35) begin n_bad++; $display("FAIL unsigned_lane0: got %h expected 00000023", out_data[31:0]); end
    for (int l = 1; l < LANES; l++) begin
      n_cmp++;
      if (out_data[l*ACC_W +: ACC_W] !== model(l, 4, 1'b0)) begin
        n_bad++; $display("FAIL unsigned_lane%0d: got %h expected %h", l, out_data[l*ACC_W +: ACC_W], model(l, 4, 1'b0));
      end
    end
    @(negedge clk);
    n_cmp++; if ({out_vld, busy} !== 2'b00) begin n_bad++; $display("FAIL handoff_idle: got %b expected 00", {out_vld, busy}); end
  endtask

  task automatic test_signed_basic();
    set_scenario1();
    start_job(4, 1'b1);
    feed(0, 4, 0);
    n_cmp++; if (out_data[31:0] !== 32'hFFFFFFF3) begin n_bad++; $display("FAIL signed_lane0: got %h expected fffffff3", out_data[31:0]); end
    n_cmp++; if (out_data[63:32] !== 32'hFFFFFFF8) begin n_bad++; $display("FAIL signed_lane1: got %h expected fffffff8", out_data[63:32]); end
    for (int l = 2; l < LANES; l++) begin
      n_cmp++;
      if (out_data[l*ACC_W +: ACC_W] !== model(l, 4, 1'b1)) begin
        n_bad++; $display("FAIL signed_lane%0d: got %h expected %h", l, out_data[l*ACC_W +: ACC_W], model(l, 4, 1'b1));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [LANES*ACC_W-1:0] exp_a;
    bit s;
    rand_job();
    s = 1'($urandom);
    for (int l = 0; l < LANES; l++) exp_a[l*ACC_W +: ACC_W] = model(l, 4, s);
    start_job(4, s);
    feed(0, 3, 0);
    out_rdy = 1'b0;
    feed(3, 4, 0);
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (out_vld !== 1'b1) begin n_bad++; $display("FAIL hold_out_vld%0d: got %b expected 1", i, out_vld); end
      n_cmp++; if (plane_rdy !== 1'b0) begin n_bad++; $display("FAIL hold_plane_rdy%0d: got %b expected 0", i, plane_rdy); end
      n_cmp++; if (out_data !== exp_a) begin n_bad++; $display("FAIL hold_out_data%0d: got %h expected %h", i, out_data, exp_a); end
      start = (i == 2);
      plane_vld = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    plane_vld = 1'b0;
    rand_job();
    s = 1'($urandom);
    drive_job(3, s);
    start = 1'b1;
    out_rdy = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if ({plane_rdy, out_vld, busy} !== 3'b101) begin n_bad++; $display("FAIL b2b_accum: got %b expected 101", {plane_rdy, out_vld, busy}); end
    feed(0, 3, 0);
    for (int l = 0; l < LANES; l++) begin
      n_cmp++;
      if (out_data[l*ACC_W +: ACC_W] !== model(l, 3, s)) begin
        n_bad++; $display("FAIL b2b_lane%0d: got %h expected %h", l, out_data[l*ACC_W +: ACC_W], model(l, 3, s));
      end
    end
  endtask

  task automatic test_gaps();
    bit s;
    rand_job();
    s = 1'($urandom);
    for (int pass = 0; pass < 2; pass++) begin
      start_job(6, s);
      feed(0, 6, pass * 3);
      for (int l = 0; l < LANES; l++) begin
        n_cmp++;
        if (out_data[l*ACC_W +: ACC_W] !== model(l, 6, s)) begin
          n_bad++; $display("FAIL gaps%0d_lane%0d: got %h expected %h", pass, l, out_data[l*ACC_W +: ACC_W], model(l, 6, s));
        end
      end
    end
  endtask

  task automatic test_bits_clamp();
    rand_job();
    pl[0][0] = 7; bias_v[0] = 1;
    start_job(0, 1'b0);
    feed(0, 1, 0);
    n_cmp++; if (out_vld !== 1'b1) begin n_bad++; $display("FAIL bits0_out_vld: got %b expected 1", out_vld); end
    n_cmp++; if (out_data[31:0] !== 32'd8) begin n_bad++; $display("FAIL bits0_lane0: got %h expected 00000008", out_data[31:0]); end
    rand_job();
    start_job(MAX_BITS + 3, 1'b1);
    feed(0, MAX_BITS - 1, 1);
    n_cmp++; if ({out_vld, plane_rdy} !== 2'b01) begin n_bad++; $display("FAIL bitsmax_early: got %b expected 01", {out_vld, plane_rdy}); end
    feed(MAX_BITS - 1, MAX_BITS, 0);
    n_cmp++; if (out_vld !== 1'b1) begin n_bad++; $display("FAIL bitsmax_out_vld: got %b expected 1", out_vld); end
    for (int l = 0; l < LANES; l++) begin
      n_cmp++;
      if (out_data[l*ACC_W +: ACC_W] !== model(l, MAX_BITS, 1'b1)) begin
        n_bad++; $display("FAIL bitsmax_lane%0d: got %h expected %h", l, out_data[l*ACC_W +: ACC_W], model(l, MAX_BITS, 1'b1));
      end
    end
  endtask

  task automatic test_abort_reset();
    logic [ACC_W-1:0] exp0;
    rand_job();
    start_job(4, 1'b0);
    feed(0, 2, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_cmp++; if ({busy, plane_rdy, out_vld} !== 3'b000) begin n_bad++; $display("FAIL abort_accum: got %b expected 000", {busy, plane_rdy, out_vld}); end
    feed(2, 4, 0);
    n_cmp++; if (out_vld !== 1'b0) begin n_bad++; $display("FAIL abort_no_result: got %b expected 0", out_vld); end
    rand_job();
    exp0 = model(0, 2, 1'b0);
    start_job(2, 1'b0);
    out_rdy = 1'b0;
    feed(0, 2, 0);
    abort = 1'b1; start = 1'b1; out_rdy = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    n_cmp++; if ({busy, out_vld} !== 2'b00) begin n_bad++; $display("FAIL abort_hold: got %b expected 00", {busy, out_vld}); end
    n_cmp++; if (out_data[31:0] !== exp0) begin n_bad++; $display("FAIL abort_keeps_data: got %h expected %h", out_data[31:0], exp0); end
    start_job(4, 1'b1);
    feed(0, 2, 0);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({busy, plane_rdy, out_vld} !== 3'b000) begin n_bad++; $display("FAIL rst_mid_ctrl: got %b expected 000", {busy, plane_rdy, out_vld}); end
    n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL rst_mid_data: got %h expected 0", out_data); end
    @(negedge clk);
    rst_n = 1'b1;
    feed(2, 4, 0);
    n_cmp++; if ({busy, out_vld} !== 2'b00) begin n_bad++; $display("FAIL rst_no_result: got %b expected 00", {busy, out_vld}); end
    set_scenario1();
    start_job(4, 1'b0);
    feed(0, 4, 2);
    n_cmp++; if (out_data[31:0] !== 32'd35) begin n_bad++; $display("FAIL fresh_lane0: got %h expected 00000023", out_data[31:0]); end
  endtask

  task automatic test_random();
    int b, n, hold;
    bit s;
    for (int j = 0; j < 25; j++) begin
      rand_job();
      b = $urandom_range(MAX_BITS + 3);
      n = (b == 0) ? 1 : (b > MAX_BITS) ? MAX_BITS : b;
      s = 1'($urandom);
      hold = $urandom_range(3);
      start_job(b, s);
      feed(0, n - 1, 2);
      out_rdy = (hold == 0);
      feed(n - 1, n, 1);
      repeat (hold) @(negedge clk);
      n_cmp++; if (out_vld !== 1'b1) begin n_bad++; $display("FAIL rand%0d_out_vld: got %b expected 1", j, out_vld); end
      for (int l = 0; l < LANES; l++) begin
        n_cmp++;
        if (out_data[l*ACC_W +: ACC_W] !== model(l, n, s)) begin
          n_bad++; $display("FAIL rand%0d_lane%0d: got %h expected %h", j, l, out_data[l*ACC_W +: ACC_W], model(l, n, s));
        end
      end
      out_rdy = 1'b1;
    end
  endtask

  task automatic test_wrap();
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      w_start = 1'b1; w_bits = 3'd2; w_signed = 1'(s); w_bias = 8'd0;
      @(negedge clk);
      w_start = 1'b0;
      w_pvld = 1'b1; w_pin = 8'h7F;
      repeat (2) @(negedge clk);
      w_pvld = 1'b0;
      n_cmp++; if (w_ovld !== 1'b1) begin n_bad++; $display("FAIL wrap%0d_out_vld: got %b expected 1", s, w_ovld); end
      n_cmp++;
      if (w_odata !== ((s == 0) ? 8'h7D : 8'h81)) begin
        n_bad++; $display("FAIL wrap%0d_data: got %h expected %h", s, w_odata, (s == 0) ? 8'h7D : 8'h81);
      end
    end
  endtask

  initial begin
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_unsigned_basic();
    test_signed_basic();
    test_back_to_back();
    test_gaps();
    test_bits_clamp();
    test_abort_reset();
    test_random();
    test_wrap();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
